// File: rtl/code_sequencer_if.sv
// code_sequencer_if: program load, run control, controller feedback and
// instruction outputs of the code sequencer.
// Optional macro CODE_SEQ_PERF_EN adds the run_cycles output.
interface code_sequencer_if #(
  parameter int OP_SIZE = 4,
  parameter int ADDR_W  = 4
);
  logic                 prog_we;
  logic [ADDR_W-1:0]    prog_addr;
  logic [OP_SIZE-1:0]   prog_op;
  logic [31:0]          prog_arg;
  logic                 start;
  logic [15:0]          epochs;
  logic                 abort;
  logic                 count_reset;
  logic                 code_active;
  logic                 code_reset;
  logic [OP_SIZE-1:0]   op;
  logic [31:0]          code_count;
  logic [31:0]          code_index;
  logic                 enable;
  logic [15:0]          epoch_index;
  logic                 done;
`ifdef CODE_SEQ_PERF_EN
  logic [31:0]          run_cycles;
`endif

  // Host / controller side.
  modport master (
    output prog_we, prog_addr, prog_op, prog_arg, start, epochs, abort,
    output count_reset, code_active, code_reset,
    input  op, code_count, code_index, enable, epoch_index, done
`ifdef CODE_SEQ_PERF_EN
    , input run_cycles
`endif
  );

  // Sequencer side.
  modport slave (
    input  prog_we, prog_addr, prog_op, prog_arg, start, epochs, abort,
    input  count_reset, code_active, code_reset,
    output op, code_count, code_index, enable, epoch_index, done
`ifdef CODE_SEQ_PERF_EN
    , output run_cycles
`endif
  );
endinterface

// File: rtl/code_sequencer.sv
// code_sequencer: holds a {op, arg} program, presents the current line to the
// training controller, counts cycles per line and replays for N epochs.
// Optional macro CODE_SEQ_PERF_EN adds a saturating run_cycles counter.
module code_sequencer #(
  parameter int OP_SIZE = 4,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  code_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         line_q, line_d;
  logic [31:0]               count_q, count_d;
  logic [15:0]               epoch_q, epoch_d;
  logic [15:0]               epochs_q, epochs_d;
  logic [OP_SIZE+31:0]       mem [DEPTH];
  logic [OP_SIZE-1:0]        cur_op;
  logic [31:0]               cur_arg;
  logic                      end_of_pass;
  logic                      start_ok;

  assign cur_op      = mem[line_q][OP_SIZE+31:32];
  assign cur_arg     = mem[line_q][31:0];
  assign end_of_pass = (cur_op == '0) ||
                       (bus.code_active && (line_q == ADDR_W'(DEPTH - 1)));
  assign start_ok    = bus.start && !bus.abort && (state_q != RUN);

  // Program store: no reset so a loaded program survives rst; locked during RUN.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (state_q != RUN) && (32'(bus.prog_addr) < DEPTH))
      mem[bus.prog_addr] <= {bus.prog_op, bus.prog_arg};
  end

  // State, line, per-line counter and epoch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      line_q   <= '0;
      count_q  <= '0;
      epoch_q  <= '0;
      epochs_q <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      count_q  <= count_d;
      epoch_q  <= epoch_d;
      epochs_q <= epochs_d;
    end
  end

  // Next-state: abort, then per-state run control in controller-feedback priority.
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    count_d  = count_q;
    epoch_d  = epoch_q;
    epochs_d = epochs_q;
    if (bus.abort) begin
      state_d = IDLE;
      line_d  = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            line_d   = '0;
            count_d  = '0;
            epoch_d  = '0;
            epochs_d = bus.epochs;
            state_d  = (bus.epochs == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (bus.code_reset) begin
            line_d  = '0;
            count_d = '0;
          end else if (end_of_pass) begin
            line_d  = '0;
            count_d = '0;
            // 17-bit compare so epoch+1 cannot wrap at 16'hFFFF.
            if (({1'b0, epoch_q} + 17'd1) < {1'b0, epochs_q})
              epoch_d = epoch_q + 16'd1;
            else
              state_d = DONE;
          end else if (bus.code_active) begin
            line_d  = line_q + ADDR_W'(1);
            count_d = '0;
          end else if (bus.count_reset) begin
            count_d = '0;
          end else if (count_q != '1) begin
            count_d = count_q + 32'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Instruction outputs are live only while running.
  always_comb begin
    bus.op          = (state_q == RUN) ? cur_op  : '0;
    bus.code_index  = (state_q == RUN) ? cur_arg : '0;
    bus.enable      = (state_q == RUN);
    bus.done        = (state_q == DONE);
    bus.code_count  = count_q;
    bus.epoch_index = epoch_q;
  end

`ifdef CODE_SEQ_PERF_EN
  logic [31:0] run_cycles_q;

  // Saturating count of cycles spent in RUN; cleared by each accepted start.
  always_ff @(posedge clk) begin
    if (rst || start_ok)
      run_cycles_q <= '0;
    else if ((state_q == RUN) && (run_cycles_q != '1))
      run_cycles_q <= run_cycles_q + 32'd1;
  end

  assign bus.run_cycles = run_cycles_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_code_sequencer.sv
// Directed testbench for code_sequencer (DEPTH=4) with a simple controller model.
module tb_code_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic auto_ctl;
  logic man_active, man_cnt_rst, man_reset;

  code_sequencer_if #(.OP_SIZE(4), .ADDR_W(2)) bus ();

  code_sequencer #(.OP_SIZE(4), .DEPTH(4), .ADDR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Controller model: finish a line when its count reaches 3; code_reset while disabled.
  assign bus.code_active = auto_ctl ? (bus.enable && bus.code_count == 32'd3) : man_active;
  assign bus.count_reset = auto_ctl ? (bus.enable && bus.code_count == 32'd3) : man_cnt_rst;
  assign bus.code_reset  = (auto_ctl && !bus.enable) || man_reset;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [1:0] a, input logic [3:0] o, input logic [31:0] g);
    bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_op = o; bus.prog_arg = g;
    step();
    bus.prog_we = 1'b0;
  endtask

  task automatic go(input logic [15:0] n);
    bus.epochs = n; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_op = '0; bus.prog_arg = '0;
    bus.start = 1'b0; bus.epochs = '0; bus.abort = 1'b0;
    auto_ctl = 1'b1; man_active = 1'b0; man_cnt_rst = 1'b0; man_reset = 1'b0;
    steps(2);
    rst = 1'b0;

    // Load program, then reset: program must survive.
    prog(2'd0, 4'd1, 32'd0);
    prog(2'd1, 4'd2, 32'd1);
    prog(2'd2, 4'd0, 32'hDEAD);
    prog(2'd3, 4'd5, 32'd7);
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    chk("rst_op", 64'(bus.op), 64'd0);
    chk("rst_count", 64'(bus.code_count), 64'd0);
    chk("rst_index", 64'(bus.code_index), 64'd0);
    chk("rst_enable", 64'(bus.enable), 64'd0);
    chk("rst_epoch", 64'(bus.epoch_index), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);

    // Single pass.
    go(16'd1);
    chk("sp_enable", 64'(bus.enable), 64'd1);
    chk("sp_op0", 64'(bus.op), 64'd1);
    chk("sp_cnt0", 64'(bus.code_count), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("sp_l0_cnt", 64'(bus.code_count), 64'(k));
      chk("sp_l0_op", 64'(bus.op), 64'd1);
    end
    step();
    chk("sp_op1", 64'(bus.op), 64'd2);
    chk("sp_idx1", 64'(bus.code_index), 64'd1);
    chk("sp_l1_cnt0", 64'(bus.code_count), 64'd0);
    steps(3);
    chk("sp_l1_cnt3", 64'(bus.code_count), 64'd3);
    step();
    chk("sp_halt_op", 64'(bus.op), 64'd0);
    chk("sp_halt_idx", 64'(bus.code_index), 64'hDEAD);
    chk("sp_halt_done", 64'(bus.done), 64'd0);
    step();
    chk("sp_done", 64'(bus.done), 64'd1);
    chk("sp_done_en", 64'(bus.enable), 64'd0);
    chk("sp_done_idx", 64'(bus.code_index), 64'd0);
`ifdef CODE_SEQ_PERF_EN
    chk("sp_run_cycles", 64'(bus.run_cycles), 64'd9);
`endif

    // Epoch replay, 9 cycles per pass.
    go(16'd3);
    chk("ep_e0", 64'(bus.epoch_index), 64'd0);
    steps(9);
    chk("ep_e1", 64'(bus.epoch_index), 64'd1);
    chk("ep_e1_op", 64'(bus.op), 64'd1);
    chk("ep_e1_done", 64'(bus.done), 64'd0);
    steps(9);
    chk("ep_e2", 64'(bus.epoch_index), 64'd2);
    chk("ep_e2_cnt", 64'(bus.code_count), 64'd0);
    steps(8);
    chk("ep_last_halt_done", 64'(bus.done), 64'd0);
    step();
    chk("ep_done", 64'(bus.done), 64'd1);
    chk("ep_done_epoch", 64'(bus.epoch_index), 64'd2);

    // Wrap: no halt marker, end of pass via code_active on line 3.
    prog(2'd2, 4'd3, 32'd2);
    prog(2'd3, 4'd4, 32'd3);
    go(16'd1);
    steps(15);
    chk("wr_l3_op", 64'(bus.op), 64'd4);
    chk("wr_l3_idx", 64'(bus.code_index), 64'd3);
    chk("wr_l3_cnt", 64'(bus.code_count), 64'd3);
    step();
    chk("wr_done", 64'(bus.done), 64'd1);
    chk("wr_en", 64'(bus.enable), 64'd0);

    // Priority and abort, manual controller.
    auto_ctl = 1'b0;
    go(16'd1);
    man_active = 1'b1; step(); man_active = 1'b0;
    chk("pr_l1_op", 64'(bus.op), 64'd2);
    steps(2);
    chk("pr_l1_cnt", 64'(bus.code_count), 64'd2);
    bus.start = 1'b1; bus.epochs = 16'd5; step(); bus.start = 1'b0;
    chk("pr_start_ign_op", 64'(bus.op), 64'd2);
    chk("pr_start_ign_cnt", 64'(bus.code_count), 64'd3);
    prog(2'd0, 4'd9, 32'd99);
    man_active = 1'b1; man_reset = 1'b1; step();
    man_active = 1'b0; man_reset = 1'b0;
    chk("pr_creset_op", 64'(bus.op), 64'd1);
    chk("pr_creset_idx", 64'(bus.code_index), 64'd0);
    chk("pr_creset_cnt", 64'(bus.code_count), 64'd0);
    steps(2);
    man_cnt_rst = 1'b1; step(); man_cnt_rst = 1'b0;
    chk("pr_cntrst_cnt", 64'(bus.code_count), 64'd0);
    chk("pr_cntrst_op", 64'(bus.op), 64'd1);
    man_cnt_rst = 1'b1; man_active = 1'b1; step();
    man_cnt_rst = 1'b0; man_active = 1'b0;
    chk("pr_both_op", 64'(bus.op), 64'd2);
    chk("pr_both_cnt", 64'(bus.code_count), 64'd0);
    bus.abort = 1'b1; step(); bus.abort = 1'b0;
    chk("ab_en", 64'(bus.enable), 64'd0);
    chk("ab_done", 64'(bus.done), 64'd0);
    chk("ab_op", 64'(bus.op), 64'd0);

    // epochs == 0 goes straight to DONE.
    go(16'd0);
    chk("e0_done", 64'(bus.done), 64'd1);
    chk("e0_en", 64'(bus.enable), 64'd0);

    // rst mid-run, then rerun the retained program.
    auto_ctl = 1'b1;
    go(16'd2);
    steps(5);
    chk("mr_pre_op", 64'(bus.op), 64'd2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mr_op", 64'(bus.op), 64'd0);
    chk("mr_en", 64'(bus.enable), 64'd0);
    chk("mr_cnt", 64'(bus.code_count), 64'd0);
    chk("mr_done", 64'(bus.done), 64'd0);
    go(16'd1);
    chk("rb_op0", 64'(bus.op), 64'd1);
    steps(4);
    chk("rb_op1", 64'(bus.op), 64'd2);
    chk("rb_idx1", 64'(bus.code_index), 64'd1);
    bus.abort = 1'b1; step(); bus.abort = 1'b0;
    chk("rb_abort_en", 64'(bus.enable), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/code_sequencer.md
# code_sequencer

Program sequencer that drives the training controller's instruction inputs. It holds a small program of `{op, arg}` lines and presents the current line as `op` / `code_index`. It also presents a per-line cycle counter as `code_count`, and replays the program for a configured number of epochs. It sits directly upstream of the controller and consumes that controller's `reset`, `code_active` and `code_reset` feedback to advance, hold or restart.

## Interface
Parameters:
- `OP_SIZE`, 4: width of the op field; must match the controller.
- `DEPTH`, 16: number of program lines.
- `ADDR_W`, 4: line address width, ceil(log2(`DEPTH`)).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `prog_we`  in  1  program write strobe; ignored unless state is IDLE or DONE.
- `prog_addr`  in  `ADDR_W`  program line to write.
- `prog_op`  in  `OP_SIZE`  op value written.
- `prog_arg`  in  32  arg value written; presented as `code_index`.
- `start`  in  1  one-cycle pulse that begins a run.
- `epochs`  in  16  passes to execute; sampled on `start`.
- `abort`  in  1  return to IDLE.
- `count_reset`  in  1  from controller `reset`; clears `code_count`.
- `code_active`  in  1  from controller; advance to the next line.
- `code_reset`  in  1  from controller; restart at line 0.
- `op`  out  `OP_SIZE`  current op.
- `code_count`  out  32  cycles spent on the current line.
- `code_index`  out  32  arg of the current line.
- `enable`  out  1  controller enable; high only in RUN.
- `epoch_index`  out  16  current pass number, 0-based.
- `done`  out  1  all epochs completed.

## Operation
- Program storage is a flop array of `DEPTH` x (`OP_SIZE`+32).
  - It is **not** cleared by `rst`, so a loaded program survives reset.
  - A write takes effect on the next edge.
- State machine, `state` ∈ {IDLE, RUN, DONE}:
  - IDLE → RUN on `start`. Sets `line`=0, `code_count`=0, `epoch_index`=0 and latches `epochs`.
    - If the latched `epochs`==0, go IDLE → DONE directly instead.
  - RUN → DONE when the end of the final pass is reached.
  - DONE → RUN on `start`, with the same initialisation as from IDLE.
  - Any state → IDLE on `abort`.
- End of pass is either condition below:
  - the current line's op == 0 (halt marker), or
  - `code_active` is asserted while `line`==`DEPTH`-1.
- At end of pass:
  - if `epoch_index`+1 < latched epochs: set `line`=0, `code_count`=0 and increment `epoch_index`;
  - otherwise go to DONE.
- RUN update priority, highest first:
  1. `rst`
  2. `abort`
  3. `code_reset`: `line`=0, `code_count`=0, epoch unchanged.
  4. end of pass
  5. `code_active`: `line`+1 and `code_count`=0.
  6. `count_reset`: `code_count`=0.
  7. otherwise `code_count`+1, saturating at 2^32-1.
- Outputs:
  - `op` = mem[`line`].op and `code_index` = mem[`line`].arg in RUN only; both are 0 in IDLE and DONE.
  - `enable` = (state==RUN).
  - `done` = (state==DONE).
  - `code_count` is a register.
- The controller's enable-low behaviour asserts `code_reset` in IDLE/DONE. This keeps `line` at 0 and has no other effect outside RUN.

## Timing
- Reset values:
  - `op`=0, `code_count`=0, `code_index`=0, `enable`=0, `epoch_index`=0, `done`=0.
  - `state`=IDLE, `line`=0.
- `op`, `code_index` and `enable` are combinational from registered `state`/`line`, so they are valid in the same cycle `line` changes.
- Latency:
  - `start` at edge N → `enable`=1 and `op`=line 0's op after edge N.
  - `code_active` sampled at edge N → new line presented, with `code_count`=0, after edge N.
- Controller feedback is combinational from `op`/`code_count`. `code_count` must only change on edges, so no combinational loop exists.
- Simultaneous `count_reset` and `code_active`: `code_active` wins; the count clears either way.
- `start` during RUN is ignored.
- `prog_we` during RUN is ignored; no write occurs.
- `rst` mid-run: outputs go to their reset values at the next edge and the program is retained.

## Configuration
- Macro: `CODE_SEQ_PERF_EN`.
- Defined:
  - Adds output `run_cycles` (32 bits), which counts cycles spent in RUN and saturates.
  - It clears on `rst` and on each accepted `start`, and holds in DONE/IDLE.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

## Test plan
- Reset: pulse `rst` 2 cycles with a prior program loaded → all outputs 0, state IDLE; readback run still executes the old program.
- Single pass:
  - Stimulus: program line0={op 1, arg 0}, line1={op 2, arg 1}, line2={op 0}; `epochs`=1; controller model raises `code_active`+`count_reset` when `code_count`==3.
  - Response: `op` sequence is 1 (counts 0..3), then 2 (counts 0..3), then DONE.
  - `done`=1 one cycle after line 2 is presented; `enable` low from then.
- Epoch replay: same program with `epochs`=3 → `epoch_index` steps 0,1,2; line 0 is re-presented twice; `done` only after the third halt.
- Wrap: `DEPTH`=4 with no halt marker, `code_active` on line 3 with `epochs`=1 → DONE; `line` never reaches 4.
- Priority/abort:
  - `code_reset`+`code_active` together on line 1 → line 0, count 0.
  - `abort` mid-run → IDLE with `enable`=0.
  - A `prog_we` during RUN leaves memory unchanged.
- Edge cases:
  - `epochs`=0 on `start` → DONE next cycle, `enable` never high.
  - With `CODE_SEQ_PERF_EN`, the two-line×4-cycle program above yields `run_cycles`=9.
